// File: rtl/rv_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) using restoring division,
// one quotient bit per cycle, with optional single-cycle special-case completion.
module rv_div #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_q;
    logic        rem_op_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic [4:0]  rd_out_q;

    // Handshake: i_start is accepted only in IDLE; while o_busy is high the
    // upstream stage holds its operands and any i_start is ignored.
    // o_valid pulses for exactly one cycle (DONE); there is no back-pressure.
    logic        is_signed;
    logic        is_rem;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] special_res;
    logic        unused_funct3;

    always_comb begin
        is_signed   = ~i_funct3[0];
        is_rem      = i_funct3[1];
        abs1        = (is_signed && i_op1[31]) ? (32'd0 - i_op1) : i_op1;
        abs2        = (is_signed && i_op2[31]) ? (32'd0 - i_op2) : i_op2;
        div_zero    = (i_op2 == 32'd0);
        overflow    = is_signed && (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
        special     = div_zero || overflow;
        special_res = 32'd0;
        if (div_zero) begin
            special_res = is_rem ? i_op1 : 32'hFFFF_FFFF;
        end else if (overflow) begin
            special_res = is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    assign unused_funct3 = i_funct3[2];

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the difference only when it does not go negative.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] final_res;

    always_comb begin
        shifted = {rem_q[31:0], quo_q[31]};
        diff    = shifted - {1'b0, div_q};
        if (!diff[32]) begin
            rem_nx = diff;
            quo_nx = {quo_q[30:0], 1'b1};
        end else begin
            rem_nx = shifted;
            quo_nx = {quo_q[30:0], 1'b0};
        end
        if (rem_op_q) begin
            final_res = r_neg_q ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];
        end else begin
            final_res = q_neg_q ? (32'd0 - quo_nx) : quo_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            div_q    <= 32'd0;
            rem_op_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else if (i_flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        rem_op_q <= is_rem;
                        q_neg_q  <= is_signed && (i_op1[31] ^ i_op2[31]) && !div_zero;
                        r_neg_q  <= is_signed && i_op1[31];
                        rd_q     <= i_rd;
                        rem_q    <= 33'd0;
                        quo_q    <= abs1;
                        div_q    <= abs2;
                        cnt_q    <= 5'd31;
                        if (FAST_SPECIAL && special) begin
                            result_q <= special_res;
                            rd_out_q <= i_rd;
                            state_q  <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        result_q <= final_res;
                        rd_out_q <= rd_q;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_result    = result_q;
    assign o_rd        = rd_out_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_rv_div.sv
// Directed bench for rv_div: one fast-special and one full-iteration instance
// driven from shared inputs, checked with immediate assertions.
module tb_rv_div;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;

    logic        busy_f, valid_f, busy_s, valid_s;
    logic [31:0] result_f, result_s;
    logic [4:0]  rd_f, rd_s;
    logic [1:0]  st_f, st_s;

    int total = 0;
    int bad   = 0;

    // per-op observations
    int          nv_f, nv_s;
    logic [31:0] lat_f, lat_s;
    logic [31:0] res_f, res_s;
    logic [4:0]  rdo_f, rdo_s;
    logic        busy0_f, busy0_s;
    logic        busy_fl_f, busy_fl_s;

    rv_div #(.FAST_SPECIAL(1'b1)) dut_f (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_start(start),
        .i_funct3(funct3), .i_op1(op1), .i_op2(op2), .i_rd(rd),
        .o_busy(busy_f), .o_valid(valid_f), .o_result(result_f), .o_rd(rd_f),
        .o_dbg_state(st_f)
    );

    rv_div #(.FAST_SPECIAL(1'b0)) dut_s (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_start(start),
        .i_funct3(funct3), .i_op1(op1), .i_op2(op2), .i_rd(rd),
        .o_busy(busy_s), .o_valid(valid_s), .o_result(result_s), .o_rd(rd_s),
        .o_dbg_state(st_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op at the next edge (E0), then watch 41 cycles. k counts
    // the edges after E0. flush_k / xstart_k inject a flush or a stray start.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input int flush_k, input int xstart_k);
        nv_f = 0; nv_s = 0;
        lat_f = 32'hFFFF_FFFF; lat_s = 32'hFFFF_FFFF;
        res_f = 32'h0; res_s = 32'h0; rdo_f = 5'h0; rdo_s = 5'h0;
        busy0_f = 1'b0; busy0_s = 1'b0; busy_fl_f = 1'b1; busy_fl_s = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; op1 = a; op2 = b; rd = r;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) begin busy0_f = busy_f; busy0_s = busy_s; end
            if (valid_f) begin nv_f++; lat_f = k; res_f = result_f; rdo_f = rd_f; end
            if (valid_s) begin nv_s++; lat_s = k; res_s = result_s; rdo_s = rd_s; end
            if (k == flush_k + 1) begin
                busy_fl_f = busy_f; busy_fl_s = busy_s; flush = 1'b0;
            end
            if (k == flush_k) flush = 1'b1;
            if (k == xstart_k + 1) start = 1'b0;
            if (k == xstart_k) begin
                start = 1'b1; funct3 = 3'b100; op1 = 32'd50; op2 = 32'd5; rd = 5'd7;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [31:0] exp, input logic [4:0] r,
                            input bit is_special);
        check({tag, "_res_f"}, res_f, exp);
        check({tag, "_res_s"}, res_s, exp);
        check({tag, "_rd_f"}, {27'd0, rdo_f}, {27'd0, r});
        check({tag, "_rd_s"}, {27'd0, rdo_s}, {27'd0, r});
        check({tag, "_lat_f"}, lat_f, is_special ? 32'd0 : 32'd32);
        check({tag, "_lat_s"}, lat_s, 32'd32);
        check({tag, "_npulse_f"}, nv_f, 32'd1);
        check({tag, "_npulse_s"}, nv_s, 32'd1);
        check({tag, "_busy0_f"}, {31'd0, busy0_f}, 32'd1);
        check({tag, "_busy0_s"}, {31'd0, busy0_s}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; start = 1'b0;
        funct3 = 3'b000; op1 = 32'd0; op2 = 32'd0; rd = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy_f", {31'd0, busy_f}, 32'd0);
        check("rst_valid_f", {31'd0, valid_f}, 32'd0);
        check("rst_result_f", result_f, 32'd0);
        check("rst_rd_f", {27'd0, rd_f}, 32'd0);
        check("rst_busy_s", {31'd0, busy_s}, 32'd0);
        check("rst_result_s", result_s, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(3'b100, 32'd100, 32'd7, 5'd5, -10, -10);
        check_op("div_100_7", 32'd14, 5'd5, 1'b0);
        do_op(3'b110, 32'd100, 32'd7, 5'd6, -10, -10);
        check_op("rem_100_7", 32'd2, 5'd6, 1'b0);
        do_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd1, -10, -10);
        check_op("div_m100_7", 32'hFFFF_FFF2, 5'd1, 1'b0);
        do_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd2, -10, -10);
        check_op("rem_m100_7", 32'hFFFF_FFFE, 5'd2, 1'b0);
        do_op(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd3, -10, -10);
        check_op("rem_100_m7", 32'd2, 5'd3, 1'b0);
        do_op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd4, -10, -10);
        check_op("divu_max_1", 32'hFFFF_FFFF, 5'd4, 1'b0);
        do_op(3'b100, 32'd5, 32'd0, 5'd8, -10, -10);
        check_op("div_5_0", 32'hFFFF_FFFF, 5'd8, 1'b1);
        do_op(3'b111, 32'd5, 32'd0, 5'd9, -10, -10);
        check_op("remu_5_0", 32'd5, 5'd9, 1'b1);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, -10, -10);
        check_op("div_ovf", 32'h8000_0000, 5'd10, 1'b1);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, -10, -10);
        check_op("rem_ovf", 32'd0, 5'd11, 1'b1);
        do_op(3'b110, 32'hFFFF_FF9C, 32'd0, 5'd12, -10, -10);
        check_op("rem_m100_0", 32'hFFFF_FF9C, 5'd12, 1'b1);

        // flush during the 10th CALC cycle
        do_op(3'b101, 32'd1000, 32'd3, 5'd13, 9, -10);
        check("flush_busy_f", {31'd0, busy_fl_f}, 32'd0);
        check("flush_busy_s", {31'd0, busy_fl_s}, 32'd0);
        check("flush_npulse_f", nv_f, 32'd0);
        check("flush_npulse_s", nv_s, 32'd0);
        check("flush_keep_res_f", result_f, 32'hFFFF_FF9C);
        check("flush_keep_res_s", result_s, 32'hFFFF_FF9C);
        check("flush_keep_rd_f", {27'd0, rd_f}, 32'd12);
        do_op(3'b101, 32'd9, 32'd3, 5'd14, -10, -10);
        check_op("divu_9_3", 32'd3, 5'd14, 1'b0);

        // stray start while busy must be ignored
        do_op(3'b100, 32'd100, 32'd7, 5'd3, -10, 5);
        check_op("busy_start", 32'd14, 5'd3, 1'b0);

        // asynchronous reset mid-CALC with a start pulse pending
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; op1 = 32'd77; op2 = 32'd7; rd = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy_f", {31'd0, busy_f}, 32'd0);
        check("arst_busy_s", {31'd0, busy_s}, 32'd0);
        check("arst_valid_s", {31'd0, valid_s}, 32'd0);
        check("arst_result_f", result_f, 32'd0);
        check("arst_result_s", result_s, 32'd0);
        check("arst_rd_s", {27'd0, rd_s}, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nv_f = 0; nv_s = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_f) nv_f++;
            if (valid_s) nv_s++;
        end
        check("arst_npulse_f", nv_f, 32'd0);
        check("arst_npulse_s", nv_s, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
